// File: rtl/dsram_arbiter_if.sv
// dsram_arbiter_if: instruction/data requester signals and the shared SRAM-like bus of dsram_arbiter.
// slave modport is the arbiter's view; master modport is the surrounding core/bus view.
interface dsram_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  modport slave (
    input  inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
           bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
           bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
  );
  modport master (
    output inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
           bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
           bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
  );
endinterface

// File: rtl/dsram_arbiter.sv
// dsram_arbiter: merges instruction and data SRAM-like requests onto one bus, one transaction outstanding.
// Ports: clk (rising edge), resetn (async active-low), io (dsram_arbiter_if.slave: inst_*, data_*, bus_*).
// Macro DSRAM_ARB_RR_EN selects round-robin; otherwise data has priority with an inst starvation guard.
module dsram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input logic            clk,
  input logic            resetn,
  dsram_arbiter_if.slave io
);
  typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_e;
  state_e      state_q, state_d;
  logic        inst_q, inst_d, wr_q, wr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        grant, pick_inst;
  logic        addr_hs, data_hs, in_wait;
  assign grant = (state_q == IDLE) && (io.inst_req || io.data_req);
`ifdef DSRAM_ARB_RR_EN
  // set when inst should win a tie, i.e. data was granted last
  logic prio_q, prio_d;
  assign pick_inst = io.inst_req && (!io.data_req || prio_q);
  assign prio_d = grant ? !pick_inst : prio_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) prio_q <= 1'b0;
    else prio_q <= prio_d;
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;
  assign pick_inst = io.inst_req && (!io.data_req || starve_q == LIMIT);
  // counts data grants that bypassed a waiting fetch
  assign starve_d = !grant ? starve_q :
                    (pick_inst || !io.inst_req) ? 4'd0 :
                    (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) starve_q <= 4'd0;
    else starve_q <= starve_d;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      inst_q  <= 1'b0;
      wr_q    <= 1'b0;
      wstrb_q <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    wr_d    = wr_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = ADDR;
        inst_d  = pick_inst;
        wr_d    = !pick_inst && io.data_wr;
        wstrb_d = pick_inst ? 4'd0 : io.data_wstrb;
        addr_d  = pick_inst ? io.inst_addr : io.data_addr;
        wdata_d = pick_inst ? 32'd0 : io.data_wdata;
      end
      ADDR: if (io.bus_addr_ok) state_d = WAIT;
      WAIT: if (io.bus_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign addr_hs         = (state_q == ADDR) && io.bus_addr_ok;
  assign in_wait         = state_q == WAIT;
  assign data_hs         = in_wait && io.bus_data_ok;
  assign io.bus_req      = state_q == ADDR;
  assign io.bus_wr       = wr_q;
  assign io.bus_wstrb    = wr_q ? wstrb_q : 4'd0;
  assign io.bus_addr     = addr_q;
  assign io.bus_wdata    = wdata_q;
  assign io.inst_addr_ok = addr_hs && inst_q;
  assign io.data_addr_ok = addr_hs && !inst_q;
  assign io.inst_data_ok = data_hs && inst_q;
  assign io.data_data_ok = data_hs && !inst_q;
  assign io.inst_rdata   = (in_wait && inst_q) ? io.bus_rdata : 32'd0;
  assign io.data_rdata   = (in_wait && !inst_q) ? io.bus_rdata : 32'd0;
endmodule
